multicycle_controller: RTL and testbench

- Next-generation MIPS control unit: multicycle Moore FSM plus ALU decoder; replaces the fixed single-cycle control-signal assignments.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, beq, addi, j, and optionally bne.
- Drives datapath muxes, write enables, PC source and ALU control.
- Supports a memory ready handshake for multi-cycle unified memory.
- Sits between the instruction register and the shared datapath.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Contents: FSM state encoding, opcode/funct constants, ALUOp codes,
// ALU control codes and datapath mux select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUOp from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // ALU B source selects
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
// Ports:
//   alu_op      in  2        operation class from the control FSM
//   funct       in  FUNCT_W  R-type funct field
//   alu_control out 3        ALU operation code
// Unknown funct values fall back to add and are not flagged.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_W'(FUNCT_ADD): alu_control = ALUC_ADD;
          FUNCT_W'(FUNCT_SUB): alu_control = ALUC_SUB;
          FUNCT_W'(FUNCT_AND): alu_control = ALUC_AND;
          FUNCT_W'(FUNCT_OR):  alu_control = ALUC_OR;
          FUNCT_W'(FUNCT_SLT): alu_control = ALUC_SLT;
          default:             alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback plus an ALU decoder.
// Ports:
//   clk, reset_n (async active-low)
//   op, funct     instruction fields from the IR
//   zero          ALU zero flag (branch resolution)
//   mem_ready     memory access completes this cycle
//   pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
//   alu_src_a, alu_src_b, pc_src, alu_control   datapath controls
//   illegal_op    one-cycle pulse in DECODE on an unsupported opcode
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int MEM_WAIT  = 1,
  parameter int EN_BNE    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 iord,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal_op
);

  state_e     state_q, state_d;
  logic       rdy;
  logic       is_bne;
  logic       pc_write;
  logic       branch;
  logic       branch_taken;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl3;

  assign rdy    = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign is_bne = (EN_BNE != 0) && (op == OP_W'(OP_BNE));
  assign branch_taken = is_bne ? ~zero : zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alu_src_b = SRCB_IMMSH;
        if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) state_d = S_MEMADR;
        else if (op == OP_W'(OP_RTYPE))               state_d = S_EXEC;
        else if (op == OP_W'(OP_BEQ) || is_bne)       state_d = S_BRANCH;
        else if (op == OP_W'(OP_ADDI))                state_d = S_ADDIEX;
        else if (op == OP_W'(OP_J))                   state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe held through wait cycles; memory commits on the ready cycle.
        iord      = 1'b1;
        mem_write = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Asserting reset kills every strobe in the same cycle so an
    // in-flight write cannot complete; selects fall back to 0/add.
    if (!reset_n) begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REGB;
      pc_src     = PCSRC_ALU;
      alu_op     = ALUOP_ADD;
      illegal_op = 1'b0;
    end
  end

  assign pc_en = pc_write | (branch & branch_taken);

  alu_decoder #(
    .FUNCT_W(FUNCT_W)
  ) u_alu_decoder (
    .alu_op     (alu_op),
    .funct      (funct),
    .alu_control(alu_ctrl3)
  );

  assign alu_control = ALUCTRL_W'(alu_ctrl3);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Two instances:
//   A: MEM_WAIT=1, EN_BNE=0, ALUCTRL_W=3
//   B: MEM_WAIT=0, EN_BNE=1, ALUCTRL_W=4 (mem_ready held low, must be ignored)
// Each cycle's expected output vector is queued when stimulus is applied
// and popped/compared mid-cycle.
module tb_multicycle_controller;

  typedef logic [16:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, zero_a, mr_a;
  logic [5:0] op_a, funct_a;
  logic       pc_en_a, iord_a, mw_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, ill_a;
  logic [1:0] asb_a, psrc_a;
  logic [2:0] aluc_a;

  logic       rst_b, zero_b, mr_b;
  logic [5:0] op_b, funct_b;
  logic       pc_en_b, iord_b, mw_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, ill_b;
  logic [1:0] asb_b, psrc_b;
  logic [3:0] aluc_b;

  multicycle_controller #(
    .OP_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .MEM_WAIT(1), .EN_BNE(0)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .op(op_a), .funct(funct_a), .zero(zero_a),
    .mem_ready(mr_a), .pc_en(pc_en_a), .iord(iord_a), .mem_write(mw_a),
    .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rdst_a), .reg_write(rw_a),
    .alu_src_a(asa_a), .alu_src_b(asb_a), .pc_src(psrc_a),
    .alu_control(aluc_a), .illegal_op(ill_a)
  );

  multicycle_controller #(
    .OP_W(6), .FUNCT_W(6), .ALUCTRL_W(4), .MEM_WAIT(0), .EN_BNE(1)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .op(op_b), .funct(funct_b), .zero(zero_b),
    .mem_ready(mr_b), .pc_en(pc_en_b), .iord(iord_b), .mem_write(mw_b),
    .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rdst_b), .reg_write(rw_b),
    .alu_src_a(asa_b), .alu_src_b(asb_b), .pc_src(psrc_b),
    .alu_control(aluc_b), .illegal_op(ill_b)
  );

  vec_t vec_a, vec_b;
  assign vec_a = {pc_en_a, iord_a, mw_a, irw_a, m2r_a, rdst_a, rw_a, asa_a,
                  asb_a, psrc_a, 1'b0, aluc_a, ill_a};
  assign vec_b = {pc_en_b, iord_b, mw_b, irw_b, m2r_b, rdst_b, rw_b, asa_b,
                  asb_b, psrc_b, aluc_b, ill_b};

  int npass = 0;
  int ntot  = 0;
  vec_t  exp_q[$];
  string tag_q[$];

  function automatic vec_t mk(input logic pce, input logic iord,
                              input logic mw, input logic irw,
                              input logic m2r, input logic rdst,
                              input logic rw, input logic asa,
                              input logic [1:0] asb, input logic [1:0] psrc,
                              input logic [3:0] alu, input logic ill);
    return {pce, iord, mw, irw, m2r, rdst, rw, asa, asb, psrc, alu, ill};
  endfunction

  // Expected per-state output vectors
  function automatic vec_t v_reset();
    return mk(0,0,0,0,0,0,0,0,2'b00,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_fetch(input logic r);
    return mk(r,0,0,r,0,0,0,0,2'b01,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_decode(input logic ill);
    return mk(0,0,0,0,0,0,0,0,2'b11,2'b00,4'h2,ill);
  endfunction
  function automatic vec_t v_memadr();
    return mk(0,0,0,0,0,0,0,1,2'b10,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_memrd();
    return mk(0,1,0,0,0,0,0,0,2'b00,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_memwb();
    return mk(0,0,0,0,1,0,1,0,2'b00,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_memwr();
    return mk(0,1,1,0,0,0,0,0,2'b00,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_exec(input logic [3:0] alu);
    return mk(0,0,0,0,0,0,0,1,2'b00,2'b00,alu,0);
  endfunction
  function automatic vec_t v_aluwb();
    return mk(0,0,0,0,0,1,1,0,2'b00,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_branch(input logic pce);
    return mk(pce,0,0,0,0,0,0,1,2'b00,2'b01,4'h6,0);
  endfunction
  function automatic vec_t v_addiwb();
    return mk(0,0,0,0,0,0,1,0,2'b00,2'b00,4'h2,0);
  endfunction
  function automatic vec_t v_jump();
    return mk(1,0,0,0,0,0,0,0,2'b00,2'b10,4'h2,0);
  endfunction

  // Queue expectation now; compare at the falling edge; return just after
  // the next rising edge so the caller can drive the following cycle.
  task automatic cyc(input int d, input vec_t e, input string tag);
    vec_t  got, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = (d == 0) ? vec_a : vec_b;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    ntot++;
    assert (got === want) npass++;
    else $error("FAIL %s: observed=%h expected=%h", t, got, want);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fl [6];
  logic [3:0] al [6];

  initial begin
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    al = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'h2};

    rst_a = 1'b0; zero_a = 1'b0; mr_a = 1'b0; op_a = 6'b100011; funct_a = '0;
    rst_b = 1'b0; zero_b = 1'b0; mr_b = 1'b0; op_b = 6'b000000; funct_b = '0;

    cyc(0, v_reset(), "reset_a");
    mr_a = 1'b1;
    cyc(0, v_reset(), "reset_a_mr_high");
    cyc(1, v_reset(), "reset_b");

    // ---- Instance A: lw with two wait cycles in FETCH and MEMRD (9 cycles)
    rst_a = 1'b1; mr_a = 1'b0; op_a = 6'b100011;
    cyc(0, v_fetch(0), "lw_fetch_wait0");
    cyc(0, v_fetch(0), "lw_fetch_wait1");
    mr_a = 1'b1;
    cyc(0, v_fetch(1), "lw_fetch");
    cyc(0, v_decode(0), "lw_decode");
    cyc(0, v_memadr(), "lw_memadr");
    mr_a = 1'b0;
    cyc(0, v_memrd(), "lw_memrd_wait0");
    cyc(0, v_memrd(), "lw_memrd_wait1");
    mr_a = 1'b1;
    cyc(0, v_memrd(), "lw_memrd");
    cyc(0, v_memwb(), "lw_memwb");
    op_a = 6'b101011;
    cyc(0, v_fetch(1), "lw_next_fetch");

    // sw, reset asserted while stalled in MEMWR
    cyc(0, v_decode(0), "sw_decode");
    cyc(0, v_memadr(), "sw_memadr");
    mr_a = 1'b0;
    cyc(0, v_memwr(), "sw_memwr_wait0");
    cyc(0, v_memwr(), "sw_memwr_wait1");
    rst_a = 1'b0;
    cyc(0, v_reset(), "reset_mid_memwr");
    rst_a = 1'b1;
    cyc(0, v_fetch(0), "post_reset_fetch_wait");
    mr_a = 1'b1; op_a = 6'b000101;
    cyc(0, v_fetch(1), "post_reset_fetch");

    // bne illegal when disabled, then 111111
    cyc(0, v_decode(1), "bne_illegal_a");
    op_a = 6'b111111;
    cyc(0, v_fetch(1), "after_illegal_bne");
    cyc(0, v_decode(1), "illegal_ff_a");
    op_a = 6'b000100; zero_a = 1'b1;
    cyc(0, v_fetch(1), "after_illegal_ff");

    // beq taken / not taken
    cyc(0, v_decode(0), "beq_decode_a");
    cyc(0, v_branch(1), "beq_taken_a");
    zero_a = 1'b0;
    cyc(0, v_fetch(1), "beq_fetch2_a");
    cyc(0, v_decode(0), "beq_decode2_a");
    cyc(0, v_branch(0), "beq_not_taken_a");
    cyc(0, v_fetch(1), "beq_end_a");
    rst_a = 1'b0;

    // ---- Instance B: mem_ready stays low and is ignored
    rst_b = 1'b1; mr_b = 1'b0; op_b = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct_b = fl[i];
      cyc(1, v_fetch(1), $sformatf("r%0d_fetch", i));
      cyc(1, v_decode(0), $sformatf("r%0d_decode", i));
      cyc(1, v_exec(al[i]), $sformatf("r%0d_exec_aluctrl", i));
      cyc(1, v_aluwb(), $sformatf("r%0d_aluwb", i));
    end

    op_b = 6'b001000;
    cyc(1, v_fetch(1), "addi_fetch");
    cyc(1, v_decode(0), "addi_decode");
    cyc(1, v_memadr(), "addi_ex");
    cyc(1, v_addiwb(), "addi_wb");

    op_b = 6'b000010;
    cyc(1, v_fetch(1), "j_fetch");
    cyc(1, v_decode(0), "j_decode");
    cyc(1, v_jump(), "j_jump");

    op_b = 6'b000101; zero_b = 1'b1;
    cyc(1, v_fetch(1), "bne_fetch1");
    cyc(1, v_decode(0), "bne_decode1");
    cyc(1, v_branch(0), "bne_zero1");
    zero_b = 1'b0;
    cyc(1, v_fetch(1), "bne_fetch2");
    cyc(1, v_decode(0), "bne_decode2");
    cyc(1, v_branch(1), "bne_zero0");

    op_b = 6'b000100; zero_b = 1'b1;
    cyc(1, v_fetch(1), "beq_fetch_b");
    cyc(1, v_decode(0), "beq_decode_b");
    cyc(1, v_branch(1), "beq_taken_b");

    op_b = 6'b100011;
    cyc(1, v_fetch(1), "lw_fetch_b");
    cyc(1, v_decode(0), "lw_decode_b");
    cyc(1, v_memadr(), "lw_memadr_b");
    cyc(1, v_memrd(), "lw_memrd_b");
    cyc(1, v_memwb(), "lw_memwb_b");

    op_b = 6'b101011;
    cyc(1, v_fetch(1), "sw_fetch_b");
    cyc(1, v_decode(0), "sw_decode_b");
    cyc(1, v_memadr(), "sw_memadr_b");
    cyc(1, v_memwr(), "sw_memwr_b");

    op_b = 6'b111111;
    cyc(1, v_fetch(1), "ill_fetch_b");
    cyc(1, v_decode(1), "ill_decode_b");
    cyc(1, v_fetch(1), "ill_next_fetch_b");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
